divider_seq: RTL

//  Sequential restoring divider: the inverse of the calculator's 4x4 array multiplier.

---
 rtl/divider_if.sv | 25 ++
 rtl/divider_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/divider_if.sv
// Start/busy/done handshake and operand/result bundle for divider_seq.
// master drives the request side; slave is the divider itself.
interface divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quot;
    logic [VW-1:0] rem;
    logic          dz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quot, rem, dz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quot, rem, dz
    );
endinterface

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Define SIGNED_DIV_EN for two's-complement truncating division (sign fix-up on the load into DONE).
module divider_seq #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [VW:0]   p_reg, p_next;
    logic [DW-1:0] q_reg, q_next;
    logic [VW-1:0] dvs_reg, dvs_next;
    logic [DW-1:0] quot_reg, quot_next;
    logic [VW-1:0] rem_reg, rem_next;
    logic          dz_reg, dz_next;

    logic [DW-1:0] a_mag;
    logic [VW-1:0] b_mag;
    logic [VW+1:0] t;
    logic          fits;
    logic [VW:0]   p_step;
    logic [DW-1:0] q_step;
    logic [DW-1:0] q_fix;
    logic [VW-1:0] r_fix;

    // One restoring step: shift {P,Q} left, trial-subtract, keep the difference only if it did not go negative.
    assign t      = {p_reg, q_reg[DW-1]} - {2'b00, dvs_reg};
    assign fits   = ~t[VW+1];
    assign p_step = fits ? t[VW:0] : {p_reg[VW-1:0], q_reg[DW-1]};
    assign q_step = {q_reg[DW-2:0], fits};

`ifdef SIGNED_DIV_EN
    logic neg_q_reg, neg_q_next;
    logic neg_r_reg, neg_r_next;

    // The core only ever sees magnitudes; the most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign a_mag = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
    assign b_mag = bus.divisor[VW-1]  ? -bus.divisor  : bus.divisor;
    assign q_fix = neg_q_reg ? -q_step : q_step;
    assign r_fix = neg_r_reg ? -p_step[VW-1:0] : p_step[VW-1:0];
`else
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
    assign q_fix = q_step;
    assign r_fix = p_step[VW-1:0];
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_next     = p_reg;
        q_next     = q_reg;
        dvs_next   = dvs_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;
        dz_next    = dz_reg;
`ifdef SIGNED_DIV_EN
        neg_q_next = neg_q_reg;
        neg_r_next = neg_r_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        dvs_next   = b_mag;
                        q_next     = a_mag;
                        p_next     = '0;
                        cnt_next   = CW'(DW - 1);
                        state_next = CALC;
`ifdef SIGNED_DIV_EN
                        neg_q_next = bus.dividend[DW-1] ^ bus.divisor[VW-1];
                        neg_r_next = bus.dividend[DW-1];
`endif
                    end else begin
                        quot_next  = '1;
                        rem_next   = '0;
                        dz_next    = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            CALC: begin
                p_next = p_step;
                q_next = q_step;
                if (cnt_reg == '0) begin
                    quot_next  = q_fix;
                    rem_next   = r_fix;
                    dz_next    = 1'b0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            p_reg     <= '0;
            q_reg     <= '0;
            dvs_reg   <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            dz_reg    <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            p_reg     <= p_next;
            q_reg     <= q_next;
            dvs_reg   <= dvs_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
            dz_reg    <= dz_next;
`ifdef SIGNED_DIV_EN
            neg_q_reg <= neg_q_next;
            neg_r_reg <= neg_r_next;
`endif
        end
    end

    assign bus.busy = (state_reg != IDLE);
    assign bus.done = (state_reg == DONE);
    assign bus.quot = quot_reg;
    assign bus.rem  = rem_reg;
    assign bus.dz   = dz_reg;
endmodule
